// File: rtl/keypad_emulator_if.sv
// Request/keypad bundle between a scanner-side test harness (master) and the
// keypad emulator (slave). Column/row lines are active-low like the real matrix.
interface keypad_emulator_if;
  logic [3:0] col;
  logic [3:0] row;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output col, req_valid, req_key,
    input  row, req_ready, busy, done, err
  );

  modport slave (
    input  col, req_valid, req_key,
    output row, req_ready, busy, done, err
  );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: presses a requested key by pulling its row low
// whenever the scanner strobes the key's column, then releases and reports.
module keypad_emulator #(
  parameter int HOLD_CYCLES    = 64,
  parameter int GAP_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input logic              clk,
  input logic              reset,
  keypad_emulator_if.slave kp
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Key code -> {column index, row index} of the physical switch.
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    logic [3:0] pos;
    case (key)
      4'hE:    pos = 4'b00_00;
      4'h7:    pos = 4'b00_01;
      4'h4:    pos = 4'b00_10;
      4'h1:    pos = 4'b00_11;
      4'h0:    pos = 4'b01_00;
      4'h8:    pos = 4'b01_01;
      4'h5:    pos = 4'b01_10;
      4'h2:    pos = 4'b01_11;
      4'hF:    pos = 4'b10_00;
      4'h9:    pos = 4'b10_01;
      4'h6:    pos = 4'b10_10;
      4'h3:    pos = 4'b10_11;
      4'hD:    pos = 4'b11_00;
      4'hC:    pos = 4'b11_01;
      4'hB:    pos = 4'b11_10;
      4'hA:    pos = 4'b11_11;
      default: pos = 4'b00_00;
    endcase
    return pos;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic [1:0]       tc_q, tc_d;
  logic [1:0]       tr_q, tr_d;
  logic             err_r_q, err_r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             hit;
  logic [3:0]       row_o;

  assign hit = (state_q == S_PRESS) && !kp.col[tc_q];

  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    tr_d    = tr_q;
    err_r_d = err_r_q;
    seen_d  = seen_q | hit;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kp.req_valid) begin
          state_d      = S_PRESS;
          {tc_d, tr_d} = key_pos(kp.req_key);
          seen_d       = 1'b0;
        end
      end
      S_PRESS: begin
        // A strobe seen at any point during the hold satisfies the press.
        if ((cnt_q >= HOLD_LAST) && (seen_q || hit)) begin
          state_d = S_RELEASE;
          err_r_d = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_RELEASE;
          err_r_d = 1'b1;
        end
      end
      S_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    err_d = done_d & err_r_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      tc_q    <= 2'd0;
      tr_q    <= 2'd0;
      err_r_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      tc_q    <= tc_d;
      tr_q    <= tr_d;
      err_r_q <= err_r_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Row follows the column strobe combinationally, like a closed switch.
  always_comb begin
    row_o = 4'b1111;
    if (hit && !reset) row_o[tr_q] = 1'b0;
  end

  assign kp.row       = row_o;
  assign kp.req_ready = (state_q == S_IDLE);
  assign kp.busy      = (state_q != S_IDLE);
  assign kp.done      = done_q;
  assign kp.err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed and random presses against a
// transaction-level model of press duration, row response and completion.
module tb_keypad_emulator;
  localparam int HOLD = 4;
  localparam int GAP  = 3;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_emulator_if kp();

  keypad_emulator #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kp)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] col_seq [0:31];
  logic [3:0] keymap [0:3][0:3] = '{'{4'hE, 4'h7, 4'h4, 4'h1},
                                     '{4'h0, 4'h8, 4'h5, 4'h2},
                                     '{4'hF, 4'h9, 4'h6, 4'h3},
                                     '{4'hD, 4'hC, 4'hB, 4'hA}};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [3:0] v);
    for (int t = 0; t < 32; t++) col_seq[t] = v;
  endtask

  // One press transaction; col_seq[t] is the column pattern t cycles after accept.
  task automatic press(input logic [3:0] key, input bit chained, input bit hold_valid);
    int tc, tr, first_hit, k, total;
    logic err_exp;
    logic [3:0] row_exp;
    tc = 0;
    tr = 0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keymap[c][r] == key) begin tc = c; tr = r; end
    first_hit = TMO + 1;
    for (int t = TMO; t >= 1; t--) if (!col_seq[t][tc]) first_hit = t;
    if (first_hit <= TMO) begin
      k = (first_hit > HOLD) ? first_hit : HOLD;
      err_exp = 1'b0;
    end else begin
      k = TMO;
      err_exp = 1'b1;
    end
    total = k + GAP + 1;
    if (!chained) begin
      @(posedge clk); #1;
      kp.req_valid = 1'b1;
      kp.req_key   = key;
      kp.col       = col_seq[0];
      @(negedge clk);
      chk($sformatf("ready_pre_k%h", key), 4'(kp.req_ready), 4'd1);
    end
    for (int t = 1; t <= total; t++) begin
      @(posedge clk); #1;
      kp.req_valid = hold_valid;
      kp.col       = col_seq[t];
      @(negedge clk);
      row_exp = 4'hF;
      if (t <= k && !col_seq[t][tc]) row_exp[tr] = 1'b0;
      chk($sformatf("row_k%h_c%0d", key, t), kp.row, row_exp);
      chk($sformatf("busy_k%h_c%0d", key, t), 4'(kp.busy), 4'(t <= k + GAP));
      chk($sformatf("ready_k%h_c%0d", key, t), 4'(kp.req_ready), 4'(t == total));
      chk($sformatf("done_k%h_c%0d", key, t), 4'(kp.done), 4'(t == total));
      chk($sformatf("err_k%h_c%0d", key, t), 4'(kp.err), (t == total) ? 4'(err_exp) : 4'd0);
    end
  endtask

  initial begin
    logic [3:0] rot [0:3];
    reset        = 1'b1;
    kp.col       = 4'hF;
    kp.req_valid = 1'b0;
    kp.req_key   = 4'h0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_row", kp.row, 4'hF);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_row2", kp.row, 4'hF);
    chk("rst_ready", 4'(kp.req_ready), 4'd1);
    chk("rst_busy", 4'(kp.busy), 4'd0);
    chk("rst_done", 4'(kp.done), 4'd0);
    chk("rst_err", 4'(kp.err), 4'd0);

    // Normal press, hit every cycle
    fill(4'b1101);
    press(4'h5, 1'b0, 1'b0);

    // Column never strobed: timeout
    fill(4'b1011);
    press(4'hE, 1'b0, 1'b0);

    // Rotating strobes
    rot[0] = 4'b1110; rot[1] = 4'b0111; rot[2] = 4'b1011; rot[3] = 4'b1101;
    for (int t = 0; t < 32; t++) col_seq[t] = rot[(t + 2) % 4];
    press(4'hD, 1'b0, 1'b0);

    // Reset mid-press aborts without done
    @(posedge clk); #1;
    kp.req_valid = 1'b1;
    kp.req_key   = 4'h2;
    kp.col       = 4'b1101;
    @(posedge clk); #1;
    kp.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_row_c1", kp.row, 4'b0111);
    chk("abort_busy_c1", 4'(kp.busy), 4'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_row_in_reset", kp.row, 4'hF);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 4'(kp.busy), 4'd0);
    chk("abort_ready", 4'(kp.req_ready), 4'd1);
    chk("abort_row", kp.row, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone_%0d", i), 4'(kp.done), 4'd0);
    end
    fill(4'b0111);
    press(4'hA, 1'b0, 1'b0);

    // Valid held through busy, back-to-back accept in the done cycle
    fill(4'b1011);
    press(4'h3, 1'b0, 1'b1);
    press(4'h3, 1'b1, 1'b0);

    // Random keys with random strobe patterns and late/no hits
    for (int n = 0; n < 10; n++) begin
      int d;
      d = int'($urandom_range(0, 20));
      for (int t = 0; t < 32; t++)
        col_seq[t] = (t <= d) ? 4'hF : 4'($urandom_range(0, 15));
      press(4'($urandom_range(0, 15)), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
